// File: rtl/cond_select_pipe_pkg.sv
// Shared branch encoding for the compare-select pipeline.
package cond_select_pkg;

   // Branch taken by the compare-select; 2'd3 is never produced.
   typedef logic [1:0] sel_t;

   localparam sel_t SEL_LT = 2'd0;
   localparam sel_t SEL_GT = 2'd1;
   localparam sel_t SEL_EQ = 2'd2;

   // LT has priority over GT; neither means the operands are equal.
   function automatic sel_t sel_encode(input logic lt, input logic gt);
      if (lt) return SEL_LT;
      if (gt) return SEL_GT;
      return SEL_EQ;
   endfunction

endpackage

// File: rtl/cond_select_pipe_cmp3.sv
// Combinational three-way comparator: signed or unsigned, EQ = neither lt nor gt.
module cmp3 #(
   parameter int CW     = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic [CW-1:0] y,
   input  logic [CW-1:0] z,
   output logic          lt,
   output logic          gt
);

   // Compare mode is fixed at elaboration time.
   if (SIGNED) begin : g_signed
      assign lt = $signed(y) < $signed(z);
      assign gt = $signed(y) > $signed(z);
   end else begin : g_unsigned
      assign lt = y < z;
      assign gt = y > z;
   end

endmodule

// File: rtl/cond_select_pipe.sv
// Two-stage valid/ready compare-select with per-branch saturating hit counters.
module cond_select_pipe
   import cond_select_pkg::*;
#(
   parameter int CW     = 4,
   parameter int DW     = 2,
   parameter bit SIGNED = 1'b0,
   parameter int CNTW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CW-1:0]   y,
   input  logic [CW-1:0]   z,
   input  logic [DW-1:0]   b,
   input  logic [DW-1:0]   c,
   input  logic [DW-1:0]   d,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [1:0]      out_sel,
   input  logic            cnt_clr,
   output logic [CNTW-1:0] cnt_lt,
   output logic [CNTW-1:0] cnt_gt,
   output logic [CNTW-1:0] cnt_eq
);

   // Global advance: both stages move together or both hold.
   logic adv;
   logic out_fire;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign out_fire = out_valid && out_ready;

   logic          s1_valid;
   logic [CW-1:0] s1_y;
   logic [CW-1:0] s1_z;
   logic [DW-1:0] s1_b;
   logic [DW-1:0] s1_c;
   logic [DW-1:0] s1_d;

   // Stage 1 valid bit: cleared by reset, follows in_valid whenever the pipe advances.
   // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)      s1_valid <= 1'b0;
      else if (adv) s1_valid <= in_valid;
   end

   // Stage 1 payload: captured on input handshake only.
   // NOTE: payload registers carry no reset; s1_valid qualifies them, so reset only needs the valid bit.
   always_ff @(posedge clk) begin
      if (adv && in_valid) begin
         s1_y <= y;
         s1_z <= z;
         s1_b <= b;
         s1_c <= c;
         s1_d <= d;
      end
   end

   logic lt;
   logic gt;

   cmp3 #(
      .CW     (CW),
      .SIGNED (SIGNED)
   ) u_cmp3 (
      .y  (s1_y),
      .z  (s1_z),
      .lt (lt),
      .gt (gt)
   );

   sel_t          nxt_sel;
   logic [DW-1:0] nxt_data;

   // Branch decode and data select on the stage 1 registers.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      nxt_sel  = sel_encode(lt, gt);
      nxt_data = s1_d;
      case (nxt_sel)
         SEL_LT:  nxt_data = s1_b;
         SEL_GT:  nxt_data = s1_c;
         default: nxt_data = s1_d;
      endcase
   end

   // Stage 2 result registers: loaded from stage 1 on advance; data only changes for real transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= SEL_EQ;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= nxt_data;
            out_sel  <= nxt_sel;
         end
      end
   end

   // Saturating increment shared by the three hit counters.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == '1) ? v : v + CNTW'(1);
   endfunction

   // LT hit counter: clear wins over a coincident handshake.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)                 cnt_lt <= '0;
      else if (out_fire && out_sel == SEL_LT) cnt_lt <= sat_inc(cnt_lt);
   end

   // GT hit counter: clear wins over a coincident handshake.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)                 cnt_gt <= '0;
      else if (out_fire && out_sel == SEL_GT) cnt_gt <= sat_inc(cnt_gt);
   end

   // EQ hit counter: clear wins over a coincident handshake.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)                 cnt_eq <= '0;
      else if (out_fire && out_sel == SEL_EQ) cnt_eq <= sat_inc(cnt_eq);
   end

endmodule

// File: tb/tb_cond_select_pipe.sv
// Bench: an unsigned/CNTW=8 instance and a signed/CNTW=2 instance share one stimulus stream.
module tb_cond_select_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] y, z;
   logic [1:0] b, c, d;
   logic       out_ready;
   logic       cnt_clr;

   logic       in_ready0, out_valid0;
   logic [1:0] out_data0, out_sel0;
   logic [7:0] cnt_lt0, cnt_gt0, cnt_eq0;

   logic       in_ready1, out_valid1;
   logic [1:0] out_data1, out_sel1;
   logic [1:0] cnt_lt1, cnt_gt1, cnt_eq1;

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   cond_select_pipe #(.CW(4), .DW(2), .SIGNED(1'b0), .CNTW(8)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .y(y), .z(z), .b(b), .c(c), .d(d),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sel(out_sel0),
      .cnt_clr(cnt_clr), .cnt_lt(cnt_lt0), .cnt_gt(cnt_gt0), .cnt_eq(cnt_eq0)
   );

   cond_select_pipe #(.CW(4), .DW(2), .SIGNED(1'b1), .CNTW(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .y(y), .z(z), .b(b), .c(c), .d(d),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sel(out_sel1),
      .cnt_clr(cnt_clr), .cnt_lt(cnt_lt1), .cnt_gt(cnt_gt1), .cnt_eq(cnt_eq1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [3:0] y, z;
      logic [1:0] b, c, d;
   } txn_t;

   // Branch from plain integer comparison: 0 = LT, 1 = GT, 2 = EQ.
   function automatic int ref_sel(input txn_t t, input bit sgn);
      int yi, zi;
      yi = int'(t.y);
      zi = int'(t.z);
      if (sgn) begin
         if (yi >= 8) yi -= 16;
         if (zi >= 8) zi -= 16;
      end
      if (yi < zi) return 0;
      if (yi > zi) return 1;
      return 2;
   endfunction

   function automatic int ref_data(input txn_t t, input bit sgn);
      int s;
      s = ref_sel(t, sgn);
      if (s == 0) return int'(t.b);
      if (s == 1) return int'(t.c);
      return int'(t.d);
   endfunction

   txn_t sb_q[$];
   int   m_cnt[2][3];
   int   m_max[2] = '{255, 3};

   // Transaction-level scoreboard evaluated mid-cycle, for the edge that follows.
   always @(negedge clk) begin
      if (mon_en) begin
         check("cnt_lt_u", 32'(cnt_lt0), 32'(m_cnt[0][0]));
         check("cnt_gt_u", 32'(cnt_gt0), 32'(m_cnt[0][1]));
         check("cnt_eq_u", 32'(cnt_eq0), 32'(m_cnt[0][2]));
         check("cnt_lt_s", 32'(cnt_lt1), 32'(m_cnt[1][0]));
         check("cnt_gt_s", 32'(cnt_gt1), 32'(m_cnt[1][1]));
         check("cnt_eq_s", 32'(cnt_eq1), 32'(m_cnt[1][2]));
         check("valid_agree", 32'(out_valid1), 32'(out_valid0));
         if (rst) begin
            sb_q.delete();
            foreach (m_cnt[i, j]) m_cnt[i][j] = 0;
         end else begin
            if (out_valid0 && out_ready) begin
               check("out_has_input", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  txn_t e;
                  e = sb_q.pop_front();
                  check("sb_data_u", 32'(out_data0), 32'(ref_data(e, 1'b0)));
                  check("sb_sel_u",  32'(out_sel0),  32'(ref_sel(e, 1'b0)));
                  check("sb_data_s", 32'(out_data1), 32'(ref_data(e, 1'b1)));
                  check("sb_sel_s",  32'(out_sel1),  32'(ref_sel(e, 1'b1)));
                  for (int u = 0; u < 2; u++) begin
                     int s;
                     s = ref_sel(e, u[0]);
                     if (m_cnt[u][s] < m_max[u]) m_cnt[u][s]++;
                  end
               end
            end
            if (cnt_clr) foreach (m_cnt[i, j]) m_cnt[i][j] = 0;
            if (in_valid && in_ready0) begin
               txn_t t;
               t.y = y; t.z = z; t.b = b; t.c = c; t.d = d;
               sb_q.push_back(t);
               check("in_flight_le2", 32'(sb_q.size() <= 2), 32'd1);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [3:0] yy, input logic [3:0] zz,
                        input logic [1:0] bb, input logic [1:0] cc, input logic [1:0] dd);
      in_valid = v;
      y = yy; z = zz; b = bb; c = cc; d = dd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
      check({tag, "_out_sel"},   32'(out_sel0),   32'd2);
      check({tag, "_out_data"},  32'(out_data0),  32'd0);
      check({tag, "_cnt_sum"},   32'(cnt_lt0) + 32'(cnt_gt0) + 32'(cnt_eq0), 32'd0);
      check({tag, "_out_valid_s"}, 32'(out_valid1), 32'd0);
      check({tag, "_cnt_s"},     32'({cnt_lt1, cnt_gt1, cnt_eq1}), 32'd0);
   endtask

   typedef struct {
      logic [3:0] y, z;
      logic [1:0] b, c, d;
      logic [1:0] data_u, sel_u, data_s, sel_s;
   } vec_t;

   vec_t vt[8];
   logic [1:0] got[$];
   logic [1:0] held;
   int k;

   initial begin
      rst = 1'b1; cnt_clr = 1'b0; out_ready = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);

      // Reset state and ready after reset.
      do_reset();
      check_reset_state("reset");
      check("reset_in_ready", 32'(in_ready0), 32'd1);
      mon_en = 1'b1;

      // Basic sequence: LT then EQ, then counters.
      out_ready = 1'b1;
      drive(1'b1, 4'd3, 4'd5, 2'd0, 2'd1, 2'd2);
      tick();
      drive(1'b1, 4'd5, 4'd5, 2'd0, 2'd1, 2'd2);
      tick();
      check("seq_lt_valid", 32'(out_valid0), 32'd1);
      check("seq_lt_data",  32'(out_data0),  32'd0);
      check("seq_lt_sel",   32'(out_sel0),   32'd0);
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      tick();
      check("seq_eq_valid", 32'(out_valid0), 32'd1);
      check("seq_eq_data",  32'(out_data0),  32'd2);
      check("seq_eq_sel",   32'(out_sel0),   32'd2);
      tick();
      check("seq_drained",  32'(out_valid0), 32'd0);
      check("seq_cnt_lt",   32'(cnt_lt0), 32'd1);
      check("seq_cnt_eq",   32'(cnt_eq0), 32'd1);
      check("seq_cnt_gt",   32'(cnt_gt0), 32'd0);

      // Table-driven single transactions, unsigned and signed expectations.
      vt[0] = '{4'h3, 4'h5, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      vt[1] = '{4'h5, 4'h5, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
      vt[2] = '{4'h7, 4'h5, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
      vt[3] = '{4'hF, 4'h1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
      vt[4] = '{4'h1, 4'hF, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd3, 2'd1};
      vt[5] = '{4'h8, 4'h7, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0};
      vt[6] = '{4'h0, 4'h0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2};
      vt[7] = '{4'hF, 4'hF, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vt[i].y, vt[i].z, vt[i].b, vt[i].c, vt[i].d);
         tick();
         drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
         tick();
         check($sformatf("vec%0d_valid", i),  32'(out_valid0), 32'd1);
         check($sformatf("vec%0d_data_u", i), 32'(out_data0),  32'(vt[i].data_u));
         check($sformatf("vec%0d_sel_u", i),  32'(out_sel0),   32'(vt[i].sel_u));
         check($sformatf("vec%0d_data_s", i), 32'(out_data1),  32'(vt[i].data_s));
         check($sformatf("vec%0d_sel_s", i),  32'(out_sel1),   32'(vt[i].sel_s));
         tick();
      end

      // Stall: four transactions, out_ready low from the second cycle.
      do_reset();
      got.delete();
      k = 0;
      held = 2'd0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = (cyc == 0 || cyc >= 6);
         if (k < 4) drive(1'b1, 4'd0, 4'd1, 2'(k), 2'(3 - k), 2'd0);
         else       drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
         #1;
         if (cyc == 2) held = out_data0;
         if (cyc >= 2 && cyc <= 5) begin
            check("stall_in_ready", 32'(in_ready0), 32'd0);
            check("stall_valid",    32'(out_valid0), 32'd1);
            check("stall_data",     32'(out_data0), 32'(held));
         end
         if (out_valid0 && out_ready) got.push_back(out_data0);
         if (in_valid && in_ready0) k++;
         tick();
      end
      check("stall_held_is_first", 32'(held), 32'd0);
      check("stall_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size() && i < 4; i++)
         check($sformatf("stall_order%0d", i), 32'(got[i]), 32'(i));

      // Saturation on the CNTW=2 instance, then clear coinciding with a GT handshake.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'd0, 4'd1, 2'd1, 2'd2, 2'd3);
         tick();
      end
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      repeat (3) tick();
      check("sat_cnt_lt_s", 32'(cnt_lt1), 32'd3);
      check("sat_cnt_lt_u", 32'(cnt_lt0), 32'd5);
      drive(1'b1, 4'd7, 4'd5, 2'd1, 2'd2, 2'd3);
      tick();
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      tick();
      check("clr_gt_pending", 32'(out_valid0 && out_sel0 == 2'd1), 32'd1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_cnt_u", 32'({cnt_lt0, cnt_gt0, cnt_eq0}), 32'd0);
      check("clr_cnt_s", 32'({cnt_lt1, cnt_gt1, cnt_eq1}), 32'd0);

      // Reset with both stages full; nothing stale may surface afterwards.
      out_ready = 1'b1;
      drive(1'b1, 4'd7, 4'd5, 2'd1, 2'd3, 2'd2);
      tick();
      out_ready = 1'b0;
      drive(1'b1, 4'd3, 4'd5, 2'd1, 2'd3, 2'd2);
      tick();
      check("pre_rst_full", 32'(out_valid0), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      drive(1'b1, 4'd5, 4'd5, 2'd1, 2'd3, 2'd2);
      tick();
      check("pre_rst_cnt", 32'(cnt_gt0), 32'd1);
      rst = 1'b1;
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      tick();
      rst = 1'b0;
      check_reset_state("midrst");
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_no_stale", 32'(out_valid0 | out_valid1), 32'd0);
      end

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
               2'($urandom), 2'($urandom), 2'($urandom));
         out_ready = $urandom_range(0, 2) != 0;
         cnt_clr   = $urandom_range(0, 31) == 0;
         tick();
      end
      drive(1'b0, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
      out_ready = 1'b1;
      cnt_clr = 1'b0;
      repeat (4) tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
